// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter that time-shares one data memory between
// port A (load/store unit) and port B (debug/DMA loader).
module dmem_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        a_valid,
    input  logic        a_we,
    input  logic [1:0]  a_size,
    input  logic        a_sign,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ready,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,

    input  logic        b_valid,
    input  logic        b_we,
    input  logic [1:0]  b_size,
    input  logic        b_sign,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ready,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,

    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_size,
    output logic        m_sign,
    output logic        m_re,
    output logic        m_we,
    input  logic [31:0] m_rdata,

    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] a_rdata_q, a_rdata_d;
    logic [31:0] b_rdata_q, b_rdata_d;

    logic grant_a;
    logic grant_b;

    always_comb begin
        // On a tie the port that did not win last time is granted; a request
        // seen while reset is asserted is never acknowledged.
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == IDLE && reset) begin
            grant_a = a_valid & (~b_valid | last_q);
            grant_b = b_valid & (~a_valid | ~last_q);
        end

        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        we_d      = we_q;
        size_d    = size_q;
        sign_d    = sign_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_a || grant_b) begin
                    state_d = ACCESS;
                    cnt_d   = LAT_M1;
                    owner_d = grant_b;
                    last_d  = grant_b;
                    we_d    = grant_b ? b_we    : a_we;
                    size_d  = grant_b ? b_size  : a_size;
                    sign_d  = grant_b ? b_sign  : a_sign;
                    addr_d  = grant_b ? b_addr  : a_addr;
                    wdata_d = grant_b ? b_wdata : a_wdata;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (owner_q) begin
                            b_rdata_d = m_rdata;
                        end else begin
                            a_rdata_d = m_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= 2'd0;
            sign_q    <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            a_rdata_q <= 32'd0;
            b_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            size_q    <= size_d;
            sign_q    <= sign_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign a_rvalid = (state_q == RESP) & ~owner_q;
    assign b_rvalid = (state_q == RESP) & owner_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

    // The latched fields double as the memory pins, so they naturally hold
    // their last values outside ACCESS.
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign m_size  = size_q;
    assign m_sign  = sign_q;
    assign m_re    = (state_q == ACCESS) & ~we_q;
    assign m_we    = (state_q == ACCESS) & we_q & (cnt_q == LAT_M1);

    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

endmodule
